decodificador_3a8_sec: RTL and testbench

Registered 3-to-8 decoder with a valid/ready handshake and timed output hold. It is the companion of the 8-to-3 priority encoder in this practice set. It accepts a 3-bit code, drives the matching one-hot line on `salidas` for a programmable number of cycles, then clears it and enforces an optional idle gap before the next code. The block drives one-hot select lines, such as LEDs or row/segment strobes, from a binary index.

---
 rtl/decodificador_3a8_sec.sv | 135 +++++++++++++
 tb/tb_decodificador_3a8_sec.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_3a8_sec.sv
// Registered 3-to-8 decoder with valid/ready handshake.
// An accepted code drives its one-hot line for HOLD_CYCLES cycles, then
// all lines stay low for GAP_CYCLES cycles before a new code is taken.
// A cancel aborts the current hold or gap and returns to idle.
module decodificador_3a8_sec #(
  parameter int HOLD_CYCLES = 4,  // 1..255
  parameter int GAP_CYCLES  = 2   // 0..255
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic [2:0] code,
  input  logic       code_valid,
  input  logic       cancel,
  output logic       ready,
  output logic [7:0] salidas,
  output logic       activa,
  output logic       done,
  output logic [2:0] ultimo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // The counter only ever holds values up to max(HOLD, GAP) - 1.
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [7:0]    salidas_q, salidas_d;
  logic          activa_q,  activa_d;
  logic          done_q,    done_d;
  logic [2:0]    ultimo_q,  ultimo_d;

  // State register: every flop of the block, cleared by the async reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      salidas_q <= '0;
      activa_q  <= 1'b0;
      done_q    <= 1'b0;
      ultimo_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      salidas_q <= salidas_d;
      activa_q  <= activa_d;
      done_q    <= done_d;
      ultimo_q  <= ultimo_d;
    end
  end

  // Next-state logic: accept in IDLE, count down the hold and the gap,
  // and let cancel win over counter expiry.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    salidas_d = salidas_q;
    activa_d  = activa_q;
    done_d    = 1'b0;
    ultimo_d  = ultimo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (code_valid && !cancel) begin
          salidas_d = 8'h01 << code;
          activa_d  = 1'b1;
          ultimo_d  = code;
          cnt_d     = HOLD_LOAD;
          state_d   = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cancel) begin
          salidas_d = '0;
          activa_d  = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          salidas_d = '0;
          activa_d  = 1'b0;
          done_d    = 1'b1;
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (cancel || cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        salidas_d = '0;
        activa_d  = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Output logic: ready is combinational on state and cancel, the rest is registered.
  always_comb begin
    ready   = (state_q == ST_IDLE) && !cancel;
    salidas = salidas_q;
    activa  = activa_q;
    done    = done_q;
    ultimo  = ultimo_q;
  end

endmodule

// File: tb/tb_decodificador_3a8_sec.sv
// Bench for decodificador_3a8_sec: two instances (HOLD=4/GAP=2 and
// HOLD=1/GAP=0), an elapsed-time model of each, an every-cycle compare
// process and directed vectors with literal expectations.
module tb_decodificador_3a8_sec;

  localparam int H0 = 4;
  localparam int G0 = 2;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] code_i   [2];
  logic       valid_i  [2];
  logic       cancel_i [2];
  logic       rdy [2];
  logic [7:0] sal [2];
  logic       act [2];
  logic       dn  [2];
  logic [2:0] ult [2];

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  decodificador_3a8_sec #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .reset(reset), .code(code_i[0]), .code_valid(valid_i[0]),
    .cancel(cancel_i[0]), .ready(rdy[0]), .salidas(sal[0]), .activa(act[0]),
    .done(dn[0]), .ultimo(ult[0])
  );

  decodificador_3a8_sec #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .reset(reset), .code(code_i[1]), .code_valid(valid_i[1]),
    .cancel(cancel_i[1]), .ready(rdy[1]), .salidas(sal[1]), .activa(act[1]),
    .done(dn[1]), .ultimo(ult[1])
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by the age (edges since the last accept) of
  // its current job; outputs follow from comparing that age with HOLD/GAP.
  bit       job  [2] = '{1'b0, 1'b0};
  int       age  [2] = '{0, 0};
  bit [2:0] mcode[2] = '{3'd0, 3'd0};
  bit [2:0] mult [2] = '{3'd0, 3'd0};

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic bit m_idle(input int i);
    return !job[i] || (age[i] >= hold_of(i) + gap_of(i));
  endfunction

  function automatic logic [7:0] m_sal(input int i);
    return (job[i] && age[i] < hold_of(i)) ? (8'h01 << mcode[i]) : 8'h00;
  endfunction

  function automatic bit m_done(input int i);
    return job[i] && (age[i] == hold_of(i));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        job[i] = 1'b0; age[i] = 0; mcode[i] = 3'd0; mult[i] = 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_idle(i) && valid_i[i] && !cancel_i[i]) begin
          job[i] = 1'b1; age[i] = 0; mcode[i] = code_i[i]; mult[i] = code_i[i];
        end else if (!m_idle(i) && cancel_i[i]) begin
          job[i] = 1'b0;
        end else if (job[i] && age[i] < 1000) begin
          age[i]++;
        end
      end
    end
  end

  // Every-cycle compare, mid-cycle (falling edge) while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cmp_salidas%0d", i), sal[i], m_sal(i));
        check($sformatf("cmp_activa%0d", i), act[i], m_sal(i) != 8'h00);
        check($sformatf("cmp_done%0d", i), dn[i], m_done(i));
        check($sformatf("cmp_ready%0d", i), rdy[i], m_idle(i) && !cancel_i[i]);
        check($sformatf("cmp_ultimo%0d", i), ult[i], mult[i]);
      end
      if (dn[0] === 1'b1) done_cnt0++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (rdy[i] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("wait_ready", rdy[i], 1);
  endtask

  logic [7:0] t2_sal  [7] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00};
  logic       t2_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       t2_rdy  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int d0;
    for (int i = 0; i < 2; i++) begin
      code_i[i] = 3'd0; valid_i[i] = 1'b0; cancel_i[i] = 1'b0;
    end

    // Reset held with code 7 offered.
    code_i[0] = 3'd7; valid_i[0] = 1'b1;
    step(); step();
    check("rst_salidas", sal[0], 8'h00);
    check("rst_activa", act[0], 0);
    check("rst_done", dn[0], 0);
    check("rst_ultimo", ult[0], 0);
    check("rst_salidas1", sal[1], 8'h00);
    reset = 1'b1;
    step();
    check("first_accept", sal[0], 8'h80);
    check("first_ultimo", ult[0], 7);
    valid_i[0] = 1'b0;
    wait_ready(0);

    // Code 5, HOLD=4, GAP=2.
    code_i[0] = 3'd5; valid_i[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step();
      valid_i[0] = 1'b0;
      check($sformatf("t2_salidas_%0d", j), sal[0], t2_sal[j]);
      check($sformatf("t2_done_%0d", j), dn[0], t2_done[j]);
      check($sformatf("t2_ready_%0d", j), rdy[0], t2_rdy[j]);
    end
    check("t2_ultimo", ult[0], 5);

    // Sweep 0..7 with code_valid held high.
    d0 = done_cnt0;
    for (int c = 0; c < 8; c++) begin
      code_i[0] = 3'(c); valid_i[0] = 1'b1;
      step();
      check($sformatf("sweep_salidas_%0d", c), sal[0], 32'h1 << c);
      wait_ready(0);
    end
    valid_i[0] = 1'b0;
    check("sweep_done_count", done_cnt0 - d0, 8);

    // Cancel in the second hold cycle, then cancel with valid in IDLE.
    code_i[0] = 3'd2; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    check("cxl_hold1", sal[0], 8'h04);
    step();
    check("cxl_hold2", sal[0], 8'h04);
    cancel_i[0] = 1'b1;
    step();
    check("cxl_cleared", sal[0], 8'h00);
    check("cxl_no_done", dn[0], 0);
    check("cxl_ready_masked", rdy[0], 0);
    code_i[0] = 3'd3; valid_i[0] = 1'b1;
    step();
    check("cxl_idle_no_accept", sal[0], 8'h00);
    check("cxl_ultimo_kept", ult[0], 2);
    cancel_i[0] = 1'b0; valid_i[0] = 1'b0;
    #1;
    check("cxl_ready_back", rdy[0], 1);

    // Cancel during the gap shortens it.
    code_i[0] = 3'd4; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    repeat (4) step();
    check("gap_done", dn[0], 1);
    cancel_i[0] = 1'b1;
    step();
    check("gap_cxl_salidas", sal[0], 8'h00);
    cancel_i[0] = 1'b0;
    #1;
    check("gap_cxl_ready", rdy[0], 1);

    // HOLD=1, GAP=0 instance.
    code_i[1] = 3'd0; valid_i[1] = 1'b1;
    step();
    check("h1_salidas_a", sal[1], 8'h01);
    check("h1_ready_a", rdy[1], 0);
    step();
    check("h1_salidas_b", sal[1], 8'h00);
    check("h1_done_b", dn[1], 1);
    check("h1_ready_b", rdy[1], 1);
    step();
    check("h1_reaccept", sal[1], 8'h01);
    check("h1_done_c", dn[1], 0);
    valid_i[1] = 1'b0;
    step();
    check("h1_done_d", dn[1], 1);
    code_i[1] = 3'd6; valid_i[1] = 1'b1;
    step();
    check("h1_salidas_e", sal[1], 8'h40);
    valid_i[1] = 1'b0; cancel_i[1] = 1'b1;
    step();
    check("h1_cxl_salidas", sal[1], 8'h00);
    check("h1_cxl_no_done", dn[1], 0);
    cancel_i[1] = 1'b0;

    // Asynchronous reset mid-hold.
    code_i[0] = 3'd6; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    step();
    check("arst_hold_pre", sal[0], 8'h40);
    reset = 1'b0;
    #1;
    check("arst_hold_salidas", sal[0], 8'h00);
    check("arst_hold_activa", act[0], 0);
    check("arst_hold_ultimo", ult[0], 0);
    check("arst_hold_done", dn[0], 0);
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("arst_release_idle", sal[0], 8'h00);
    check("arst_release_ready", rdy[0], 1);

    // Asynchronous reset mid-gap.
    code_i[0] = 3'd1; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    repeat (5) step();
    check("arst_gap_pre_ready", rdy[0], 0);
    check("arst_gap_pre_ultimo", ult[0], 1);
    reset = 1'b0;
    #1;
    check("arst_gap_salidas", sal[0], 8'h00);
    check("arst_gap_done", dn[0], 0);
    check("arst_gap_ultimo", ult[0], 0);
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("arst_gap_release_ready", rdy[0], 1);
    check("arst_gap_release_salidas", sal[0], 8'h00);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
